vga_timing_gen: RTL and testbench

- Upstream timing stage for the parallax renderer: generates the VGA raster (pixel enable, h/v counters, sync, blanking) that the renderer consumes to produce rgb.
- Also supplies line/frame strobes and a free-running frame counter used for scroll offsets.
- Fully synchronous. All outputs are flops; no combinational decode reaches the pins.

---
 rtl/vga_timing_gen.sv | 140 ++++++++++++++
 tb/tb_vga_timing_gen.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel-enable divider, h/v counters, sync/blank decode,
// line/frame strobes and a free-running completed-frame counter.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int SYNC_POL = 0,
  parameter int CLK_DIV  = 1,
  parameter int FRAME_W  = 16
) (
  input  logic               clk,
  input  logic               reset,
  output logic               pix_en,
  output logic [9:0]         x,
  output logic [9:0]         y,
  output logic               display_on,
  output logic               hsync,
  output logic               vsync,
  output logic               line_start,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > 1024) begin : g_h_total_err
    $error("vga_timing_gen: H_TOTAL exceeds 1024");
  end
  if (V_TOTAL > 1024) begin : g_v_total_err
    $error("vga_timing_gen: V_TOTAL exceeds 1024");
  end
  if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_div_err
    $error("vga_timing_gen: CLK_DIV out of range 1..16");
  end

  localparam logic [3:0]  DIV_LAST = 4'(CLK_DIV - 1);
  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
  localparam logic [10:0] X_ACT    = 11'(H_ACTIVE);
  localparam logic [10:0] Y_ACT    = 11'(V_ACTIVE);
  localparam logic [10:0] HS_BEG   = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_BEG   = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic        ACT      = (SYNC_POL != 0);

  logic [3:0]         div;
  logic [3:0]         div_nxt;
  logic               adv;
  logic               x_wrap;
  logic               y_wrap;
  logic [9:0]         x_nxt;
  logic [9:0]         y_nxt;
  logic [10:0]        xw;
  logic [10:0]        yw;
  logic               ls_nxt;
  logic               fs_nxt;
  logic               de_nxt;
  logic               hs_nxt;
  logic               vs_nxt;
  logic [FRAME_W-1:0] fc_nxt;

  // pix_en is the registered image of div reaching its last count,
  // and the counters step on that same edge.
  always_comb begin
    adv     = (div == DIV_LAST);
    div_nxt = adv ? 4'd0 : div + 4'd1;
  end

  always_comb begin
    x_wrap = ({1'b0, x} == H_LAST);
    y_wrap = ({1'b0, y} == V_LAST);
    x_nxt  = x;
    y_nxt  = y;
    ls_nxt = 1'b0;
    fs_nxt = 1'b0;
    fc_nxt = frame_cnt;
    unique case (1'b1)
      !adv: begin
      end
      adv && !x_wrap: begin
        x_nxt = x + 10'd1;
      end
      adv && x_wrap && !y_wrap: begin
        x_nxt  = 10'd0;
        y_nxt  = y + 10'd1;
        ls_nxt = 1'b1;
      end
      default: begin
        x_nxt  = 10'd0;
        y_nxt  = 10'd0;
        ls_nxt = 1'b1;
        fs_nxt = 1'b1;
        fc_nxt = frame_cnt + FRAME_W'(1);
      end
    endcase
  end

  // Decode from next-state counters so sync/blank line up with x/y.
  always_comb begin
    xw     = {1'b0, x_nxt};
    yw     = {1'b0, y_nxt};
    de_nxt = (xw < X_ACT) && (yw < Y_ACT);
    hs_nxt = ((xw >= HS_BEG) && (xw < HS_END)) ? ACT : ~ACT;
    vs_nxt = ((yw >= VS_BEG) && (yw < VS_END)) ? ACT : ~ACT;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div         <= 4'd0;
      pix_en      <= 1'b0;
      x           <= 10'd0;
      y           <= 10'd0;
      display_on  <= 1'b1;
      hsync       <= ~ACT;
      vsync       <= ~ACT;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      div         <= div_nxt;
      pix_en      <= adv;
      x           <= x_nxt;
      y           <= y_nxt;
      display_on  <= de_nxt;
      hsync       <= hs_nxt;
      vsync       <= vs_nxt;
      line_start  <= ls_nxt;
      frame_start <= fs_nxt;
      frame_cnt   <= fc_nxt;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: two small-raster instances (div 1 / active-low,
// div 3 / active-high / 2-bit frame counter) against an arithmetic model.
module tb_vga_timing_gen;

  localparam int HA = 8;
  localparam int HF = 2;
  localparam int HS = 3;
  localparam int HB = 2;
  localparam int VA = 6;
  localparam int VF = 1;
  localparam int VS = 2;
  localparam int VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int DA = 1;
  localparam int DB = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic       pe_a, de_a, hs_a, vs_a, ls_a, fs_a;
  logic [9:0] x_a, y_a;
  logic [15:0] fc_a;
  logic       pe_b, de_b, hs_b, vs_b, ls_b, fs_b;
  logic [9:0] x_b, y_b;
  logic [1:0] fc_b;

  int k = 0;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  always @(posedge clk) k <= reset ? 0 : k + 1;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(0), .CLK_DIV(DA), .FRAME_W(16)
  ) dut_a (
    .clk(clk), .reset(reset), .pix_en(pe_a), .x(x_a), .y(y_a),
    .display_on(de_a), .hsync(hs_a), .vsync(vs_a),
    .line_start(ls_a), .frame_start(fs_a), .frame_cnt(fc_a)
  );

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(1), .CLK_DIV(DB), .FRAME_W(2)
  ) dut_b (
    .clk(clk), .reset(reset), .pix_en(pe_b), .x(x_b), .y(y_b),
    .display_on(de_b), .hsync(hs_b), .vsync(vs_b),
    .line_start(ls_b), .frame_start(fs_b), .frame_cnt(fc_b)
  );

  // Expected outputs kk clocks after the reset edge: pixel p = kk/d.
  function automatic logic [41:0] model(int kk, int d, bit pol, int w);
    int p, xx, yy, ff;
    logic pe, ls, fs, de, h, v;
    p  = kk / d;
    xx = p % HT;
    yy = (p / HT) % VT;
    ff = (p / (HT * VT)) % (1 << w);
    pe = (kk > 0) && (kk % d == 0);
    ls = pe && (xx == 0);
    fs = ls && (yy == 0);
    de = (xx < HA) && (yy < VA);
    h  = (xx >= HA + HF && xx < HA + HF + HS) ? pol : ~pol;
    v  = (yy >= VA + VF && yy < VA + VF + VS) ? pol : ~pol;
    return {pe, 10'(xx), 10'(yy), de, h, v, ls, fs, 16'(ff)};
  endfunction

  function automatic logic [41:0] obs_a();
    return {pe_a, x_a, y_a, de_a, hs_a, vs_a, ls_a, fs_a, fc_a};
  endfunction

  function automatic logic [41:0] obs_b();
    return {pe_b, x_b, y_b, de_b, hs_b, vs_b, ls_b, fs_b, 14'd0, fc_b};
  endfunction

  task automatic test_reset();
    logic [41:0] ea, eb;
    reset = 1'b1;
    repeat (4) begin
      @(negedge clk);
      ea = model(0, DA, 1'b0, 16);
      eb = model(0, DB, 1'b1, 2);
      checks++;
      if (obs_a() !== ea) begin
        failures++;
        $display("FAIL reset_a got=%h exp=%h", obs_a(), ea);
      end
      checks++;
      if (obs_b() !== eb) begin
        failures++;
        $display("FAIL reset_b got=%h exp=%h", obs_b(), eb);
      end
    end
  endtask

  task automatic test_raster(int n);
    logic [41:0] ea, eb;
    reset = 1'b0;
    repeat (n) begin
      @(negedge clk);
      ea = model(k, DA, 1'b0, 16);
      eb = model(k, DB, 1'b1, 2);
      checks++;
      if (obs_a() !== ea) begin
        failures++;
        $display("FAIL raster_a k=%0d got=%h exp=%h", k, obs_a(), ea);
      end
      checks++;
      if (obs_b() !== eb) begin
        failures++;
        $display("FAIL raster_b k=%0d got=%h exp=%h", k, obs_b(), eb);
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [41:0] ea, eb;
    int run, hold;
    for (int r = 0; r < 4; r++) begin
      run  = $urandom_range(20, 500);
      hold = $urandom_range(1, 3);
      for (int i = 0; i < run + hold + 40; i++) begin
        reset = (i >= run) && (i < run + hold);
        @(negedge clk);
        ea = model(k, DA, 1'b0, 16);
        eb = model(k, DB, 1'b1, 2);
        checks++;
        if (obs_a() !== ea) begin
          failures++;
          $display("FAIL midreset_a k=%0d got=%h exp=%h", k, obs_a(), ea);
        end
        checks++;
        if (obs_b() !== eb) begin
          failures++;
          $display("FAIL midreset_b k=%0d got=%h exp=%h", k, obs_b(), eb);
        end
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_frame_counts();
    int de_n, hs_n, vs_n, ls_n, fs_n;
    de_n = 0; hs_n = 0; vs_n = 0; ls_n = 0; fs_n = 0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < HT * VT; i++) begin
      de_n += int'(de_a);
      hs_n += int'(!hs_a);
      vs_n += int'(!vs_a);
      ls_n += int'(ls_a);
      fs_n += int'(fs_a);
      @(negedge clk);
    end
    checks++;
    if (de_n != HA * VA) begin
      failures++;
      $display("FAIL display_count got=%0d exp=%0d", de_n, HA * VA);
    end
    checks++;
    if (hs_n != HS * VT) begin
      failures++;
      $display("FAIL hsync_count got=%0d exp=%0d", hs_n, HS * VT);
    end
    checks++;
    if (vs_n != VS * HT) begin
      failures++;
      $display("FAIL vsync_count got=%0d exp=%0d", vs_n, VS * HT);
    end
    checks++;
    if (ls_n != VT - 1 || fs_n != 0) begin
      failures++;
      $display("FAIL strobe_count ls=%0d fs=%0d exp ls=%0d fs=0",
               ls_n, fs_n, VT - 1);
    end
    checks++;
    if (!(fs_a && ls_a && x_a == 0 && y_a == 0 && fc_a == 16'd1)) begin
      failures++;
      $display("FAIL first_wrap fs=%b ls=%b x=%0d y=%0d fc=%0d exp 1 1 0 0 1",
               fs_a, ls_a, x_a, y_a, fc_a);
    end
  endtask

  task automatic test_frame_cnt_wrap();
    logic [1:0] seq [5];
    logic [1:0] prev;
    int n, last_k, budget;
    seq[0] = 2'd1; seq[1] = 2'd2; seq[2] = 2'd3; seq[3] = 2'd0; seq[4] = 2'd1;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n = 0;
    last_k = 0;
    prev = fc_b;
    budget = 6 * HT * VT * DB + 50;
    while (n < 5 && budget > 0) begin
      @(negedge clk);
      budget--;
      if (fc_b !== prev && !fs_b) begin
        checks++;
        failures++;
        $display("FAIL fc_change_without_fs k=%0d got=%0d prev=%0d", k, fc_b, prev);
      end
      if (fs_b) begin
        checks++;
        if (fc_b !== seq[n]) begin
          failures++;
          $display("FAIL fc_seq idx=%0d got=%0d exp=%0d", n, fc_b, seq[n]);
        end
        checks++;
        if (k - last_k != HT * VT * DB) begin
          failures++;
          $display("FAIL frame_period got=%0d exp=%0d", k - last_k, HT * VT * DB);
        end
        last_k = k;
        n++;
      end
      prev = fc_b;
    end
    if (n < 5) begin
      checks++;
      failures++;
      $display("FAIL fc_wrap_timeout frames=%0d exp=5", n);
    end
  endtask

  initial begin
    test_reset();
    test_raster(3 * HT * VT * DB);
    test_mid_reset();
    test_frame_counts();
    test_frame_cnt_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
